universal_ff_bank: RTL

- WIDTH-bit bank of edge-triggered flip-flops with a run-time mode select: D, T, JK or SR.
- Parametrised successor to the team's single-bit SR and master-slave D flip-flops.
- SR S=R=1 is resolved deterministically: the affected bits hold, and the event is flagged and logged.
- Used as the common storage primitive for control registers and toggle/status bits.

---
 rtl/uff_pkg.sv | 51 +++++
 rtl/universal_ff_bank_if.sv | 31 +++
 rtl/uff_bit.sv | 41 ++++
 rtl/universal_ff_bank.sv | 90 +++++++++
 4 files changed

// File: rtl/uff_pkg.sv
// uff_pkg: shared definitions for the universal flip-flop bank.
//   - uff_mode_e : operation select encoding (D, T, JK, SR)
//   - uff_next_t : next-state result of one bit (next q + illegal flag)
//   - uff_next() : single-bit next-state function used by every cell
package uff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } uff_mode_e;

  typedef struct packed {
    logic q;
    logic illegal;
  } uff_next_t;

  // SR with S=R=1 holds the current value so no X can ever be stored;
  // the caller decides whether the illegal flag matters (it is gated by en).
  function automatic uff_next_t uff_next(input logic [1:0] mode,
                                         input logic a,
                                         input logic b,
                                         input logic q);
    uff_next_t r;
    r.q       = q;
    r.illegal = 1'b0;
    case (mode)
      MODE_D:  r.q = a;
      MODE_T:  r.q = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   r.q = 1'b0;
          2'b10:   r.q = 1'b1;
          2'b11:   r.q = ~q;
          default: r.q = q;
        endcase
      end
      default: begin
        case ({a, b})
          2'b01:   r.q = 1'b0;
          2'b10:   r.q = 1'b1;
          2'b11:   r.illegal = 1'b1;
          default: r.q = q;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/universal_ff_bank_if.sv
// universal_ff_bank_if: control/data bundle of the flip-flop bank.
//   master : drives en, mode, a, b, err_clr; observes Q, Qbar, err, err_bits
//   slave  : the bank side (inverse directions)
// ill_cnt exists only when UFF_ILLEGAL_CNT_EN is defined.
interface universal_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             err;
  logic [WIDTH-1:0] err_bits;
`ifdef UFF_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] ill_cnt;

  modport master (output en, mode, a, b, err_clr,
                  input  Q, Qbar, err, err_bits, ill_cnt);
  modport slave  (input  en, mode, a, b, err_clr,
                  output Q, Qbar, err, err_bits, ill_cnt);
`else
  modport master (output en, mode, a, b, err_clr,
                  input  Q, Qbar, err, err_bits);
  modport slave  (input  en, mode, a, b, err_clr,
                  output Q, Qbar, err, err_bits);
`endif
endinterface

// File: rtl/uff_bit.sv
// uff_bit: one flip-flop cell of the universal bank.
//   clk, rst    : clock, synchronous active-high reset (loads RST_VAL)
//   en_i        : update enable (0 = hold, no illegal indication)
//   mode_i      : D / T / JK / SR select
//   a_i, b_i    : D/T/J/S and -/-/K/R inputs
//   q_o, qbar_o : state and its complement
//   illegal_o   : this cycle is an enabled SR with S=R=1 (combinational)
module uff_bit
  import uff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       q_o,
  output logic       qbar_o,
  output logic       illegal_o
);

  logic      q_q, q_d;
  uff_next_t nxt;

  always_comb begin
    nxt       = uff_next(mode_i, a_i, b_i, q_q);
    q_d       = en_i ? nxt.q : q_q;
    illegal_o = en_i & nxt.illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q_o    = q_q;
  assign qbar_o = ~q_q;

endmodule

// File: rtl/universal_ff_bank.sv
// universal_ff_bank: WIDTH-bit bank of D/T/JK/SR flip-flops with sticky
// illegal-SR tracking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : universal_ff_bank_if.slave (en, mode, a, b, err_clr in;
//              Q, Qbar, err, err_bits [, ill_cnt] out)
// Optional: define UFF_ILLEGAL_CNT_EN to add the saturating illegal-cycle
// counter ill_cnt (CNT_W bits).
module universal_ff_bank
  import uff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  universal_ff_bank_if.slave    bus
);

  logic [WIDTH-1:0] q_w, qbar_w, ill_w;
  logic             any_ill;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    uff_bit #(.RST_VAL(RESET_VAL[i])) u_bit (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.en),
      .mode_i    (bus.mode),
      .a_i       (bus.a[i]),
      .b_i       (bus.b[i]),
      .q_o       (q_w[i]),
      .qbar_o    (qbar_w[i]),
      .illegal_o (ill_w[i])
    );
  end

  assign any_ill  = |ill_w;
  assign bus.Q    = q_w;
  assign bus.Qbar = qbar_w;

  logic             err_q, err_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;

  // Clear is applied first so a coinciding illegal cycle leaves only its
  // own bits recorded.
  always_comb begin
    err_d      = err_q;
    err_bits_d = err_bits_q;
    if (bus.err_clr) begin
      err_d      = 1'b0;
      err_bits_d = '0;
    end
    if (any_ill) begin
      err_d      = 1'b1;
      err_bits_d = err_bits_d | ill_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_bits_q <= '0;
    end else begin
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
    end
  end

  assign bus.err      = err_q;
  assign bus.err_bits = err_bits_q;

`ifdef UFF_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One count per illegal cycle regardless of how many bits were illegal.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.err_clr) cnt_d = '0;
    if (any_ill && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.ill_cnt = cnt_q;
`endif

endmodule
